// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC owner, imem request, skid-buffered decode output
//
// Ports:
//   i_clk, i_rst_n              clock (rising edge), asynchronous active-low reset
//   i_redirect, i_redirect_pc   one-cycle taken-branch pulse and its resolved target
//   i_halt                      decode holds HALT; stop fetching for good
//   o_imem_req, o_imem_addr     fetch request and address (stable while outstanding)
//   i_imem_rdy, i_imem_data     memory completes the current request this cycle
//   i_id_stall                  decode cannot take the if_* outputs this cycle
//   o_if_valid, o_if_instr      decode-side instruction (NOP_INSTR when not valid)
//   o_if_pc, o_if_pc_inc        address of o_if_instr and that address + 2
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_rdy,
    input  logic [15:0] i_imem_data,
    input  logic        i_id_stall,
    output logic        o_if_valid,
    output logic [15:0] o_if_instr,
    output logic [15:0] o_if_pc,
    output logic [15:0] o_if_pc_inc
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic [15:0] r_pc,         w_pc_nxt;
    logic        r_req_busy,   w_req_busy_nxt;
    logic [15:0] r_req_addr,   w_req_addr_nxt;
    logic        r_kill,       w_kill_nxt;
    logic        r_out_valid,  w_out_valid_nxt;
    logic [15:0] r_out_instr,  w_out_instr_nxt;
    logic [15:0] r_out_pc,     w_out_pc_nxt;
    logic        r_skid_valid, w_skid_valid_nxt;
    logic [15:0] r_skid_instr, w_skid_instr_nxt;
    logic [15:0] r_skid_pc,    w_skid_pc_nxt;

    logic        w_imem_req;
    logic [15:0] w_addr;
    logic        w_resp;
    logic        w_start;
    logic        w_pending;
    logic        w_consume;
    logic        w_halted;
    logic        w_do_redirect;
    logic        w_do_halt;

    assign w_imem_req    = (r_state == ST_FETCH) | ((r_state == ST_DRAIN) & r_req_busy);
    assign w_addr        = r_req_busy ? r_req_addr : r_pc;
    assign w_resp        = w_imem_req & i_imem_rdy;
    assign w_start       = w_imem_req & ~r_req_busy;
    // A request that will still be outstanding after this edge, including one
    // starting right now: its eventual response belongs to the old path.
    assign w_pending     = w_imem_req & ~i_imem_rdy;
    assign w_consume     = r_out_valid & ~i_id_stall;
    assign w_halted      = (r_state == ST_HALTED);
    assign w_do_redirect = i_redirect & ~w_halted;
    assign w_do_halt     = i_halt & ~i_redirect & ~w_halted;

    // Request is forced low during reset even though the FSM sits in FETCH.
    assign o_imem_req  = w_imem_req & i_rst_n;
    assign o_imem_addr = w_addr;
    assign o_if_valid  = r_out_valid;
    assign o_if_instr  = r_out_valid ? r_out_instr : NOP_INSTR;
    assign o_if_pc     = r_out_pc;
    assign o_if_pc_inc = r_out_pc + 16'd2;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_req_busy_nxt   = r_req_busy;
        w_req_addr_nxt   = r_req_addr;
        w_kill_nxt       = r_kill;
        w_out_valid_nxt  = r_out_valid;
        w_out_instr_nxt  = r_out_instr;
        w_out_pc_nxt     = r_out_pc;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;

        // Handshake bookkeeping runs regardless of redirect/halt so the
        // address stays pinned until memory actually completes.
        if (w_resp) begin
            w_req_busy_nxt = 1'b0;
        end else if (w_start) begin
            w_req_busy_nxt = 1'b1;
            w_req_addr_nxt = r_pc;
        end

        if (w_do_redirect) begin
            w_pc_nxt         = i_redirect_pc;
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
            w_kill_nxt       = w_pending;
            w_state_nxt      = ST_FETCH;
        end else if (w_do_halt) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
            w_kill_nxt       = w_pending;
            w_state_nxt      = w_pending ? ST_DRAIN : ST_HALTED;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_resp && !r_kill) begin
                        w_pc_nxt = r_pc + 16'd2;
                        if (!r_out_valid || w_consume) begin
                            w_out_valid_nxt = 1'b1;
                            w_out_instr_nxt = i_imem_data;
                            w_out_pc_nxt    = w_addr;
                        end else begin
                            w_skid_valid_nxt = 1'b1;
                            w_skid_instr_nxt = i_imem_data;
                            w_skid_pc_nxt    = w_addr;
                            w_state_nxt      = ST_HOLD;
                        end
                    end else begin
                        if (w_resp) begin
                            w_kill_nxt = 1'b0;
                        end
                        if (w_consume) begin
                            w_out_valid_nxt = 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_consume) begin
                        w_out_valid_nxt  = 1'b1;
                        w_out_instr_nxt  = r_skid_instr;
                        w_out_pc_nxt     = r_skid_pc;
                        w_skid_valid_nxt = 1'b0;
                        w_state_nxt      = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (w_resp) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = ST_HALTED;
                    end
                end
                default: begin
                    w_out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_req_busy   <= 1'b0;
            r_req_addr   <= RESET_PC;
            r_kill       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_instr  <= NOP_INSTR;
            r_out_pc     <= 16'h0000;
            r_skid_valid <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_req_busy   <= w_req_busy_nxt;
            r_req_addr   <= w_req_addr_nxt;
            r_kill       <= w_kill_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_instr  <= w_out_instr_nxt;
            r_out_pc     <= w_out_pc_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a wait-state memory model
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;
    localparam logic [15:0] KEY = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        id_stall = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_inc;

    int errors = 0;
    int checks = 0;

    // Memory: completes a request after cur_wait cycles of it being held,
    // data is a fixed function of the address.
    int wcnt = 0;
    int rnd_wait = 0;
    int mem_wait = 0;
    bit rand_mode = 1'b0;
    int cur_wait;

    always_comb cur_wait = rand_mode ? rnd_wait : mem_wait;
    assign imem_rdy  = imem_req && (wcnt >= cur_wait);
    assign imem_data = imem_addr ^ KEY;

    always @(posedge clk) begin
        if (imem_req && !imem_rdy) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (imem_req && imem_rdy) rnd_wait <= $urandom_range(0, 3);
    end

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_halt(halt),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_rdy(imem_rdy), .i_imem_data(imem_data),
        .i_id_stall(id_stall),
        .o_if_valid(if_valid), .o_if_instr(if_instr),
        .o_if_pc(if_pc), .o_if_pc_inc(if_pc_inc)
    );

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0; redirect = 1'b0; halt = 1'b0; id_stall = 1'b0;
        redirect_pc = 16'h0000; mem_wait = 0; rand_mode = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%h want=0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%h want=0", if_valid); end
        checks++; if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h want=%h", if_instr, NOP); end
        checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h want=0000", if_pc); end
        checks++; if (if_pc_inc !== 16'h0002) begin errors++; $display("FAIL reset_pc_inc got=%h want=0002", if_pc_inc); end
    endtask

    // Ends on the negedge where if_pc should be 4.
    task automatic test_sequential();
        logic [15:0] e;
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_first_req got=%h want=1", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL seq_first_addr got=%h want=0000", imem_addr); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            e = 16'(2 * k);
            checks++; if (imem_addr !== e) begin errors++; $display("FAIL seq_addr k=%0d got=%h want=%h", k, imem_addr, e); end
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid k=%0d got=%h want=1", k, if_valid); end
            checks++; if (if_pc !== e - 16'd2) begin errors++; $display("FAIL seq_pc k=%0d got=%h want=%h", k, if_pc, e - 16'd2); end
            checks++; if (if_pc_inc !== e) begin errors++; $display("FAIL seq_pc_inc k=%0d got=%h want=%h", k, if_pc_inc, e); end
            checks++; if (if_instr !== ((e - 16'd2) ^ KEY)) begin errors++; $display("FAIL seq_instr k=%0d got=%h want=%h", k, if_instr, (e - 16'd2) ^ KEY); end
        end
    endtask

    task automatic test_stall();
        id_stall = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            checks++; if (if_pc !== 16'h0004 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_hold s=%0d got pc=%h v=%h want pc=0004 v=1", s, if_pc, if_valid); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req s=%0d got=%h want=0", s, imem_req); end
        end
        id_stall = 1'b0;
        @(negedge clk);
        checks++; if (if_pc !== 16'h0006 || if_instr !== (16'h0006 ^ KEY)) begin errors++; $display("FAIL stall_skid got pc=%h instr=%h want pc=0006 instr=%h", if_pc, if_instr, 16'h0006 ^ KEY); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin errors++; $display("FAIL stall_resume got req=%h addr=%h want req=1 addr=0008", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (if_pc !== 16'h0008 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_next got pc=%h v=%h want pc=0008 v=1", if_pc, if_valid); end
    endtask

    task automatic test_redirect_wait();
        hold_reset();
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 16'h0020;
        @(negedge clk);
        redirect = 1'b0; mem_wait = 3;
        for (int a = 0; a < 4; a++) begin
            if (a > 0) @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin errors++; $display("FAIL rdw_addr a=%0d got req=%h addr=%h want req=1 addr=0020", a, imem_req, imem_addr); end
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rdw_valid a=%0d got=%h want=0", a, if_valid); end
            if (a == 1) begin redirect = 1'b1; redirect_pc = 16'h0100; end
            else redirect = 1'b0;
        end
        mem_wait = 0;
        @(negedge clk);
        checks++; if (imem_addr !== 16'h0100 || if_valid !== 1'b0) begin errors++; $display("FAIL rdw_target got addr=%h v=%h want addr=0100 v=0", imem_addr, if_valid); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_instr !== (16'h0100 ^ KEY)) begin errors++; $display("FAIL rdw_first got v=%h pc=%h instr=%h want v=1 pc=0100 instr=%h", if_valid, if_pc, if_instr, 16'h0100 ^ KEY); end
    endtask

    task automatic test_redirect_halt();
        redirect = 1'b1; redirect_pc = 16'h0200; halt = 1'b1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0200) begin errors++; $display("FAIL rh_wins got v=%h req=%h addr=%h want v=0 req=1 addr=0200", if_valid, imem_req, imem_addr); end
        redirect = 1'b0; halt = 1'b1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rh_halt got v=%h req=%h want v=0 req=0", if_valid, imem_req); end
        halt = 1'b0; redirect = 1'b1; redirect_pc = 16'h0300;
        @(negedge clk);
        redirect = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_instr !== NOP) begin errors++; $display("FAIL rh_halted got req=%h v=%h instr=%h want req=0 v=0 instr=%h", imem_req, if_valid, if_instr, NOP); end
        end
    endtask

    task automatic test_wrap();
        hold_reset();
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr got=%h want=fffe", imem_addr); end
        @(negedge clk);
        checks++; if (if_pc !== 16'hFFFE || if_pc_inc !== 16'h0000 || if_valid !== 1'b1) begin errors++; $display("FAIL wrap_out got pc=%h inc=%h v=%h want pc=fffe inc=0000 v=1", if_pc, if_pc_inc, if_valid); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next_addr got=%h want=0000", imem_addr); end
        @(negedge clk);
        checks++; if (if_pc !== 16'h0000 || if_pc_inc !== 16'h0002) begin errors++; $display("FAIL wrap_after got pc=%h inc=%h want pc=0000 inc=0002", if_pc, if_pc_inc); end
    endtask

    task automatic test_reset_mid();
        mem_wait = 5; id_stall = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b1 || if_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got req=%h v=%h want req=1 v=1", imem_req, if_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rmid_async got req=%h v=%h want 0 0", imem_req, if_valid); end
        checks++; if (if_instr !== NOP || if_pc !== 16'h0000 || if_pc_inc !== 16'h0002) begin errors++; $display("FAIL rmid_vals got instr=%h pc=%h inc=%h want %h 0000 0002", if_instr, if_pc, if_pc_inc, NOP); end
        mem_wait = 0; id_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rmid_first got req=%h addr=%h want req=1 addr=0000", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin errors++; $display("FAIL rmid_out got v=%h pc=%h want v=1 pc=0000", if_valid, if_pc); end
    endtask

    // Program-order scoreboard: decode must see exactly the sequence
    // target, target+2, ... between redirects, each word matching memory.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] prev_addr;
        bit          prev_pend;
        int          consumed;
        int          n;
        hold_reset();
        rand_mode = 1'b1;
        rst_n = 1'b1;
        exp_pc = 16'h0000; prev_pend = 1'b0; prev_addr = 16'h0000; consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            if (prev_pend) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin errors++; $display("FAIL rnd_addr_stable c=%0d got req=%h addr=%h want req=1 addr=%h", c, imem_req, imem_addr, prev_addr); end
            end
            id_stall = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom_range(0, 32767) * 2);
            #1;
            prev_pend = imem_req && !imem_rdy;
            prev_addr = imem_addr;
            if (if_valid === 1'b1) begin
                checks++; if (if_instr !== (if_pc ^ KEY) || if_pc_inc !== if_pc + 16'd2) begin errors++; $display("FAIL rnd_word c=%0d pc=%h got instr=%h inc=%h want instr=%h inc=%h", c, if_pc, if_instr, if_pc_inc, if_pc ^ KEY, if_pc + 16'd2); end
            end else begin
                checks++; if (if_instr !== NOP) begin errors++; $display("FAIL rnd_nop c=%0d got=%h want=%h", c, if_instr, NOP); end
            end
            if (redirect) begin
                exp_pc = redirect_pc;
            end else if (if_valid === 1'b1 && !id_stall) begin
                checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL rnd_order c=%0d got pc=%h want pc=%h", c, if_pc, exp_pc); end
                exp_pc = exp_pc + 16'd2;
                consumed++;
            end
        end
        checks++; if (consumed < 300) begin errors++; $display("FAIL rnd_progress got=%0d want>=300", consumed); end
        @(negedge clk);
        redirect = 1'b0; id_stall = 1'b0; halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rnd_halt_flush got=%h want=0", if_valid); end
        n = 0;
        while (imem_req === 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_halt_drain req still high after %0d cycles", n); end
        repeat (3) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rnd_halted got req=%h v=%h want 0 0", imem_req, if_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
